// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit RV32 ALU between NUM_REQ requesters.
// The winning request is executed in its grant cycle. Its result is held in a
// single-entry response buffer until the owning requester takes it.
// A drain and a new accept can happen in the same cycle, so the block can
// sustain one operation per cycle.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [4*NUM_REQ-1:0]    i_req_op,
  input  logic [32*NUM_REQ-1:0]   i_req_a,
  input  logic [32*NUM_REQ-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]      o_resp_valid,
  input  logic [NUM_REQ-1:0]      i_resp_ready,
  output logic [31:0]             o_resp_data,
  output logic [ID_W-1:0]         o_resp_id,
  output logic                    o_busy
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        rst_sync_q;
  logic              run;

  logic              any_valid;
  logic [ID_W-1:0]   winner;
  logic [3:0]        alu_op;
  logic [31:0]       alu_a, alu_b, alu_res;
  logic signed [31:0] sra_res;
  logic              full, own_ready, drain, can_accept, accept;

  // Reset is asserted asynchronously but released internally only after two
  // clock edges, so no request is accepted on the edge that ends reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  // Round-robin search: scan from rr_ptr upwards, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    logic            cand_valid;
    any_valid  = 1'b0;
    winner     = '0;
    sum        = '0;
    cand       = '0;
    cand_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand       = sum[ID_W-1:0];
      cand_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (cand == ID_W'(k)) begin
          cand_valid = i_req_valid[k];
        end
      end
      if (!any_valid && cand_valid) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Steer the winner's operation and operands into the shared ALU.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        alu_op = i_req_op[4*k +: 4];
        alu_a  = i_req_a[32*k +: 32];
        alu_b  = i_req_b[32*k +: 32];
      end
    end
  end

  // The arithmetic shift is kept separate so that it stays signed.
  assign sra_res = $signed(alu_a) >>> alu_b[4:0];

  // RV32 integer ALU. Bit 3 selects SUB and SRA, and the shift amount is b[4:0].
  always_comb begin
    alu_res = '0;
    unique case (alu_op[2:0])
      3'd0: alu_res = alu_op[3] ? (alu_a - alu_b) : (alu_a + alu_b);
      3'd1: alu_res = alu_a << alu_b[4:0];
      3'd2: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd3: alu_res = {31'd0, alu_a < alu_b};
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = alu_op[3] ? sra_res : (alu_a >> alu_b[4:0]);
      3'd6: alu_res = alu_a | alu_b;
      3'd7: alu_res = alu_a & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Select the ready bit of the current owner of the buffer. Ready bits of
  // other requesters have no effect.
  always_comb begin
    own_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (id_q == ID_W'(k)) begin
        own_ready = i_resp_ready[k];
      end
    end
  end

  assign full       = (state_q == StFull);
  assign drain      = full && own_ready;
  assign can_accept = run && (!full || own_ready);
  assign accept     = any_valid && can_accept;

  // Drive the one-hot handshake outputs for the request side and the response side.
  always_comb begin
    o_req_ready  = '0;
    o_resp_valid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k]  = accept && (winner == ID_W'(k));
      o_resp_valid[k] = full && (id_q == ID_W'(k));
    end
  end

  assign o_resp_data = data_q;
  assign o_resp_id   = id_q;
  assign o_busy      = full;

  // Compute the next state of the buffer and of the round-robin pointer.
  // An accept that coincides with a drain refills the buffer.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      state_d  = StFull;
      data_d   = alu_res;
      id_d     = winner;
      rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : (winner + ID_W'(1));
    end else if (drain) begin
      state_d  = StEmpty;
    end
  end

  // Registers for the buffer state, the buffered result and the pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. It drives a 2-requester and a 3-requester instance.
// Expected grants and responses are queued as stimulus is issued. Monitors
// pop and compare them when a handshake completes.
module tb_alu_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  valid2, rdy2, rvalid2, rready2, rid2;
  logic [7:0]  op2;
  logic [63:0] a2, b2;
  logic [31:0] rdata2;
  logic        busy2;

  logic [2:0]  valid3, rdy3, rvalid3, rready3;
  logic [11:0] op3;
  logic [95:0] a3, b3;
  logic [31:0] rdata3;
  logic [1:0]  rid3;
  logic        busy3;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_grant2[$];
  int          exp_grant3[$];
  resp_t       exp_resp2[$];
  resp_t       exp_resp3[$];

  logic [1:0]  pend2;
  logic [7:0]  op2_s;
  logic [63:0] a2_s, b2_s;
  logic [2:0]  pend3;
  logic [11:0] op3_s;
  logic [95:0] a3_s, b3_s;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(2), .ID_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid2), .o_req_ready(rdy2),
    .i_req_op(op2), .i_req_a(a2), .i_req_b(b2),
    .o_resp_valid(rvalid2), .i_resp_ready(rready2),
    .o_resp_data(rdata2), .o_resp_id(rid2), .o_busy(busy2)
  );

  alu_arbiter #(.NUM_REQ(3), .ID_W(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid3), .o_req_ready(rdy3),
    .i_req_op(op3), .i_req_a(a3), .i_req_b(b3),
    .o_resp_valid(rvalid3), .i_resp_ready(rready3),
    .o_resp_data(rdata3), .o_resp_id(rid3), .o_busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an unexpected handshake, expected none (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op2[4*k +: 4] = op;
    a2[32*k +: 32] = a;
    b2[32*k +: 32] = b;
  endtask

  task automatic set3(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op3[4*k +: 4] = op;
    a3[32*k +: 32] = a;
    b3[32*k +: 32] = b;
  endtask

  task automatic push2(input int g, input logic [31:0] d);
    resp_t e;
    e.id = 2'(g);
    e.data = d;
    exp_grant2.push_back(g);
    exp_resp2.push_back(e);
  endtask

  task automatic push3(input int g, input logic [31:0] d);
    resp_t e;
    e.id = 2'(g);
    e.data = d;
    exp_grant3.push_back(g);
    exp_resp3.push_back(e);
  endtask

  // Monitor for the 2-requester DUT, plus the requester-stability assertion.
  always @(negedge clk) begin
    int    g;
    resp_t e;
    for (int k = 0; k < 2; k++) begin
      if (pend2[k] && valid2[k]) begin
        assert (op2[4*k +: 4] == op2_s[4*k +: 4] && a2[32*k +: 32] == a2_s[32*k +: 32] &&
                b2[32*k +: 32] == b2_s[32*k +: 32])
          else $error("requester %0d of dut2 changed its request while pending", k);
      end
      if (valid2[k] && rdy2[k]) begin
        if (exp_grant2.size() == 0) fail_event("grant2_extra");
        else begin
          g = exp_grant2.pop_front();
          check("grant2", k, g);
        end
      end
      if (rvalid2[k] && rready2[k]) begin
        if (exp_resp2.size() == 0) fail_event("resp2_extra");
        else begin
          e = exp_resp2.pop_front();
          check("resp2_owner", k, 32'(e.id));
          check("resp2_id", 32'(rid2), 32'(e.id));
          check("resp2_data", rdata2, e.data);
        end
      end
    end
    pend2 <= valid2 & ~rdy2;
    op2_s <= op2;
    a2_s  <= a2;
    b2_s  <= b2;
  end

  // Monitor for the 3-requester DUT, plus the requester-stability assertion.
  always @(negedge clk) begin
    int    g;
    resp_t e;
    for (int k = 0; k < 3; k++) begin
      if (pend3[k] && valid3[k]) begin
        assert (op3[4*k +: 4] == op3_s[4*k +: 4] && a3[32*k +: 32] == a3_s[32*k +: 32] &&
                b3[32*k +: 32] == b3_s[32*k +: 32])
          else $error("requester %0d of dut3 changed its request while pending", k);
      end
      if (valid3[k] && rdy3[k]) begin
        if (exp_grant3.size() == 0) fail_event("grant3_extra");
        else begin
          g = exp_grant3.pop_front();
          check("grant3", k, g);
        end
      end
      if (rvalid3[k] && rready3[k]) begin
        if (exp_resp3.size() == 0) fail_event("resp3_extra");
        else begin
          e = exp_resp3.pop_front();
          check("resp3_owner", k, 32'(e.id));
          check("resp3_id", 32'(rid3), 32'(e.id));
          check("resp3_data", rdata3, e.data);
        end
      end
    end
    pend3 <= valid3 & ~rdy3;
    op3_s <= op3;
    a3_s  <= a3;
    b3_s  <= b3;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    rst_n   = 1'b0;
    valid2  = '0; rready2 = '0; op2 = '0; a2 = '0; b2 = '0;
    valid3  = '0; rready3 = '0; op3 = '0; a3 = '0; b3 = '0;
    pend2   = '0; op2_s = '0; a2_s = '0; b2_s = '0;
    pend3   = '0; op3_s = '0; a3_s = '0; b3_s = '0;

    // Reset state: ready stays low even with a request valid.
    set2(0, 4'b0000, 32'd5, 32'd3);
    valid2 = 2'b01;
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", 32'(rdy2), 32'h0);
    check("rst_resp_valid", 32'(rvalid2), 32'h0);
    check("rst_resp_data", rdata2, 32'h0);
    check("rst_resp_id", 32'(rid2), 32'h0);
    check("rst_busy", 32'(busy2), 32'h0);
    check("rst_req_ready3", 32'(rdy3), 32'h0);
    tick();
    valid2 = 2'b00;
    rst_n  = 1'b1;
    repeat (3) tick();

    // Test 1: single requester running ADD, then SUB twice.
    rready2 = 2'b11;
    set2(0, 4'b0000, 32'd5, 32'd3);
    valid2 = 2'b01;
    push2(0, 32'd8);
    @(negedge clk);
    check("t1_req_ready", 32'(rdy2), 32'h1);
    tick();
    set2(0, 4'b1000, 32'd5, 32'd3);
    push2(0, 32'd2);
    @(negedge clk);
    check("t1_resp_valid", 32'(rvalid2), 32'h1);
    check("t1_resp_data", rdata2, 32'd8);
    check("t1_resp_id", 32'(rid2), 32'h0);
    tick();
    set2(0, 4'b1000, 32'd0, 32'd1);
    push2(0, 32'hFFFF_FFFF);
    tick();
    valid2 = 2'b00;
    repeat (4) tick();

    // Test 4: the pointer is 1 and holds through idle cycles, so req1 wins first.
    set2(0, 4'b1101, 32'h8000_0000, 32'd4);
    set2(1, 4'b0011, 32'd1, 32'hFFFF_FFFF);
    valid2 = 2'b11;
    push2(1, 32'd1);
    @(negedge clk);
    check("t4_req_ready", 32'(rdy2), 32'h2);
    tick();
    valid2 = 2'b00;
    tick();

    // Test 2: contention with SRA and SLTU. Grants alternate at one per cycle.
    valid2 = 2'b11;
    push2(0, 32'hF800_0000);
    push2(1, 32'd1);
    push2(0, 32'hF800_0000);
    push2(1, 32'd1);
    repeat (4) tick();
    valid2 = 2'b00;
    repeat (2) tick();

    // Test 3: backpressure holds the result, then a drain and an accept happen together.
    rready2 = 2'b00;
    set2(0, 4'b0100, 32'h0000_FF00, 32'h0000_0FF0);
    valid2 = 2'b01;
    push2(0, 32'h0000_F0F0);
    tick();
    set2(1, 4'b0110, 32'h0000_00F0, 32'h0000_0F00);
    valid2 = 2'b10;
    push2(1, 32'h0000_0FF0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_data", rdata2, 32'h0000_F0F0);
      check("t3_hold_ready", 32'(rdy2), 32'h0);
      check("t3_hold_valid", 32'(rvalid2), 32'h1);
      tick();
    end
    rready2 = 2'b11;
    @(negedge clk);
    check("t3_drain_accept", 32'(rdy2), 32'h2);
    tick();
    valid2 = 2'b00;
    repeat (2) tick();

    // Test 5: reset while the buffer holds 0x1234 and the pointer is 1.
    rready2 = 2'b00;
    set2(0, 4'b0000, 32'h0000_1000, 32'h0000_0234);
    valid2 = 2'b01;
    exp_grant2.push_back(0);
    tick();
    set2(0, 4'b1000, 32'h0000_1000, 32'h0000_0234);
    set2(1, 4'b0000, 32'd7, 32'd8);
    valid2 = 2'b11;
    push2(0, 32'h0000_0DCC);
    @(negedge clk);
    check("t5_full_data", rdata2, 32'h0000_1234);
    check("t5_full_valid", 32'(rvalid2), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(rvalid2), 32'h0);
    check("t5_async_busy", 32'(busy2), 32'h0);
    check("t5_async_data", rdata2, 32'h0);
    check("t5_async_ready", 32'(rdy2), 32'h0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    rready2 = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy2 != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_grant_seen", 32'(got), 32'h1);
    tick();
    valid2 = 2'b00;
    repeat (2) tick();

    // Test 6: three requesters with round-robin order 0,1,2,0. SLL uses only b[4:0].
    rready3 = 3'b111;
    set3(0, 4'b0001, 32'd1, 32'd33);
    set3(1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    set3(2, 4'b0111, 32'h0000_F0F0, 32'h0000_0FF0);
    valid3 = 3'b111;
    push3(0, 32'd2);
    push3(1, 32'd1);
    push3(2, 32'h0000_00F0);
    push3(0, 32'd2);
    repeat (4) tick();
    valid3 = 3'b000;
    repeat (4) tick();

    check("left_grant2", 32'(exp_grant2.size()), 32'h0);
    check("left_resp2", 32'(exp_resp2.size()), 32'h0);
    check("left_grant3", 32'(exp_grant3.size()), 32'h0);
    check("left_resp3", 32'(exp_resp3.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's `alu` between NUM_REQ requesters, e.g. the execute stage, an address-generation helper and a debug/CSR unit.
- Requests use a valid/ready handshake and are arbitrated round-robin.
- The selected operation runs through the ALU in the grant cycle; its result is captured in a single-entry response buffer and returned to the granted requester with its own valid/ready handshake.
- Sustains one operation per cycle when the response side does not stall.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- ID_W, 2, width of the granted-requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  request k valid.
- o_req_ready  output  NUM_REQ  request k accepted this cycle (one-hot or zero).
- i_req_op  input  4*NUM_REQ  ALU op of requester k, bits [4k+3:4k]. Bit 3 selects SUB/SRA; bits 2:0 are RV32 funct3 (0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND).
- i_req_a  input  32*NUM_REQ  operand A of requester k.
- i_req_b  input  32*NUM_REQ  operand B of requester k.
- o_resp_valid  output  NUM_REQ  result pending for requester k (one-hot or zero).
- i_resp_ready  input  NUM_REQ  requester k consumes its result.
- o_resp_data  output  32  buffered ALU result, shared by all requesters.
- o_resp_id  output  ID_W  index of the requester owning o_resp_data.
- o_busy  output  1  response buffer occupied.

Behaviour:
- Reset (async assert, sync deassert internally), all outputs and state go to zero:
  - o_resp_valid = 0, o_resp_data = 0, o_resp_id = 0, o_busy = 0.
  - Round-robin pointer rr_ptr = 0.
  - o_req_ready = 0 while i_rst_n is low.
- Reset mid-operation discards any buffered result. No response is issued for it after reset.
- Buffer state machine: EMPTY / FULL.
  - can_accept = EMPTY, or FULL with i_resp_ready[o_resp_id] high this cycle (drain and refill in the same cycle).
- Arbitration (combinational, same cycle):
  - Search i_req_valid starting at index rr_ptr, then rr_ptr+1, and so on, wrapping at NUM_REQ. The first valid index is the winner g.
  - o_req_ready[g] = can_accept; all other ready bits are 0.
  - The ALU is fed with the winner's op/A/B. With no valid request the ALU inputs are don't-care and o_req_ready = 0.
- Accept (valid & ready for g) at edge N:
  - Buffer loads the ALU output and o_resp_id = g.
  - FULL is asserted from cycle N+1. Latency is 1 cycle from accept to o_resp_valid.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- rr_ptr is unchanged on cycles with no accept, including a stalled winner.
- Starvation bound: a continuously-valid requester is granted within NUM_REQ accepts.
- Response:
  - o_resp_valid[o_resp_id] = FULL.
  - o_resp_data and o_resp_id are held stable while valid is high and ready is low.
  - FULL -> EMPTY on i_resp_ready[o_resp_id] with no new accept.
  - FULL -> FULL on drain plus accept, with the new data loaded.
  - i_resp_ready bits of non-owners are ignored.
- Requester obligation, checked by a bench assertion: while i_req_valid[k] is high and not yet accepted, op/A/B of requester k stay stable.
- Arithmetic is identical to `alu`:
  - 32-bit wrap-around on ADD/SUB.
  - Shift amount is B[4:0].
  - SLT is signed; SLTU is unsigned.
- A requester may issue back-to-back only if it drains its response. The block does not reorder; exactly one result is outstanding.

Test Plan:
1. Single requester: after reset, req0 ADD A=5 B=3 -> o_req_ready[0]=1 the same cycle; next cycle o_resp_valid=01, o_resp_data=8, o_resp_id=0. Then op 4'b1000 (SUB) with A=5 B=3 -> 2; A=0 B=1 SUB -> 0xFFFFFFFF.
2. Contention, NUM_REQ=2, both requesters valid continuously with i_resp_ready all 1:
   - req0 op 5'd? SRA: op 4'b1101, A=0x80000000, B=4.
   - req1 SLTU: A=1, B=0xFFFFFFFF.
   - Required: grants alternate 0,1,0,1. Results alternate 0xF8000000 and 1, one per cycle.
3. Backpressure: req0 XOR A=0xFF00 B=0x0FF0 accepted; hold i_resp_ready=0 for 3 cycles while req1 is valid.
   - Required: o_resp_data stays 0xF0F0 and o_req_ready stays 00.
   - On the ready cycle, req1 is accepted in the same cycle as the drain, with no bubble.
4. Pointer hold: rr_ptr=1, then 4 idle cycles, then both valid -> req1 granted first.
5. Reset mid-operation: buffer FULL with 0x1234; assert i_rst_n low for 1 cycle between edges.
   - Required: o_resp_valid drops immediately (async) and rr_ptr=0.
   - After release with both requesters valid, req0 is granted.
6. NUM_REQ=3, all valid, resp always ready -> grant order 0,1,2,0. SLL A=1 B=33 -> 2 (only B[4:0] used).
